// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-client memory access arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ     = 2;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin grant; on a tie the requester that did
// not win last time is chosen.
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_idx,
    output logic               valid
);

    always_comb begin
        grant     = '0;
        grant_idx = 1'b0;
        valid     = |req;
        case (req)
            2'b01: begin
                grant     = 2'b01;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant     = 2'b10;
                grant_idx = 1'b1;
            end
            2'b11: begin
                grant_idx = ~last_grant;
                grant     = last_grant ? 2'b01 : 2'b10;
            end
            default: begin
                grant     = '0;
                grant_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin controller sharing one single-port memory between the tx and rx
// clients: one transaction at a time, with timeout abort on a missing ack.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic                last_grant_q;
    logic                gnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [NUM_REQ-1:0]  arb_grant;
    logic                arb_idx;
    logic                arb_valid;
    logic                handshake;
    logic                timed_out;
    logic                in_access;

    rr_arbiter_2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .valid      (arb_valid)
    );

    assign in_access = (state_q == READ) || (state_q == WRITE);
    assign timed_out = (cnt_q == CNT_LAST);
    assign handshake = (state_q == IDLE) && arb_valid && !rst;
    assign req_ready = handshake ? arb_grant : '0;

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = req_write[arb_idx] ? WRITE : READ;
                end
            end
            READ, WRITE: begin
                if (mem_ack || timed_out) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            busy         <= 1'b0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (handshake) begin
                last_grant_q <= arb_idx;
                gnt_q        <= arb_idx;
                addr_q       <= arb_idx ? req_addr[2*ADDR_W-1:ADDR_W]
                                        : req_addr[ADDR_W-1:0];
                wdata_q      <= arb_idx ? req_wdata[2*DATA_W-1:DATA_W]
                                        : req_wdata[DATA_W-1:0];
                cnt_q        <= '0;
            end else if (in_access && !mem_ack) begin
                cnt_q <= cnt_q + 1'b1;
            end

            // Outputs are registered from the next state so they line up
            // with the state they describe.
            mem_en <= (state_d == READ) || (state_d == WRITE);
            mem_we <= (state_d == WRITE);
            busy   <= (state_d != IDLE);

            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            if (in_access && (state_d == DONE)) begin
                rsp_valid[gnt_q] <= 1'b1;
                if (mem_ack) begin
                    rsp_data <= (state_q == READ) ? mem_rdata : '0;
                end else begin
                    rsp_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: handshake timing, round-robin ties,
// timeout abort, reset mid-transaction and spurious acks.
module tb_mem_access_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0]           req_write;
    logic [2*ADDR_W-1:0]  req_addr;
    logic [2*DATA_W-1:0]  req_wdata;
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic                 mem_ack;
    logic [DATA_W-1:0]    mem_rdata;
    logic [1:0]           rsp_valid;
    logic [DATA_W-1:0]    rsp_data;
    logic                 rsp_err;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int n_en;

    mem_access_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_en"},    64'(mem_en),    64'd0);
        check({tag, "_mem_we"},    64'(mem_we),    64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
        check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        tick(); tick();
        check_quiet("reset");

        // --- single read on req 0, ack in second mem_en cycle ---
        rst       = 1'b0;
        req_valid = 2'b01;
        req_addr  = {8'h00, 8'h10};
        settle();
        check("rd_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        settle();
        check("rd_en", 64'(mem_en), 64'd1);
        check("rd_we", 64'(mem_we), 64'd0);
        check("rd_addr", 64'(mem_addr), 64'h10);
        check("rd_busy", 64'(busy), 64'd1);
        check("rd_ready_busy", 64'(req_ready), 64'd0);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack   = 1'b0;
        check("rd_rsp_valid", 64'(rsp_valid), 64'h1);
        check("rd_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
        check("rd_rsp_err", 64'(rsp_err), 64'd0);
        check("rd_done_en", 64'(mem_en), 64'd0);
        tick();
        check("rd_idle_rsp", 64'(rsp_valid), 64'd0);
        check("rd_idle_busy", 64'(busy), 64'd0);

        // --- tie from reset: req 0 write, then req 1 read, then req 0 again ---
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 2'b11;
        req_write = 2'b01;
        req_addr  = {8'h30, 8'h20};
        req_wdata = {32'h0, 32'h1};
        settle();
        check("tie1_ready", 64'(req_ready), 64'h1);
        tick();
        check("tie1_we", 64'(mem_we), 64'd1);
        check("tie1_addr", 64'(mem_addr), 64'h20);
        check("tie1_wdata", 64'(mem_wdata), 64'h1);
        check("tie1_ready_busy", 64'(req_ready), 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        tick();
        mem_ack = 1'b0;
        check("tie1_rsp_valid", 64'(rsp_valid), 64'h1);
        check("tie1_rsp_data", 64'(rsp_data), 64'h0);
        check("tie1_rsp_err", 64'(rsp_err), 64'd0);
        check("tie1_done_ready", 64'(req_ready), 64'd0);
        tick();
        check("tie2_ready", 64'(req_ready), 64'h2);
        tick();
        check("tie2_we", 64'(mem_we), 64'd0);
        check("tie2_addr", 64'(mem_addr), 64'h30);
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        check("tie2_rsp_valid", 64'(rsp_valid), 64'h2);
        check("tie2_rsp_data", 64'(rsp_data), 64'h12345678);
        tick();
        check("tie3_ready", 64'(req_ready), 64'h1);
        req_valid = 2'b00;
        req_write = 2'b00;

        // --- timeout: ack withheld ---
        mem_rdata = 32'hA5A5A5A5;
        req_valid = 2'b01;
        req_addr  = {8'h00, 8'h44};
        tick();
        req_valid = 2'b00;
        n_en = 0;
        while (mem_en === 1'b1 && n_en < 40) begin
            n_en++;
            tick();
        end
        check("to_en_cycles", 64'(n_en), 64'(TIMEOUT));
        check("to_rsp_valid", 64'(rsp_valid), 64'h1);
        check("to_rsp_err", 64'(rsp_err), 64'd1);
        check("to_rsp_data", 64'(rsp_data), 64'h0);
        tick();
        check("to_idle_busy", 64'(busy), 64'd0);
        check("to_idle_rsp", 64'(rsp_valid), 64'd0);

        // --- ack on the last permitted cycle wins over the timeout ---
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("edge_en_last", 64'(mem_en), 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE0001;
        tick();
        mem_ack = 1'b0;
        check("edge_rsp_valid", 64'(rsp_valid), 64'h1);
        check("edge_rsp_err", 64'(rsp_err), 64'd0);
        check("edge_rsp_data", 64'(rsp_data), 64'hCAFE0001);
        tick();

        // --- reset while req 0 write is waiting for ack ---
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr  = {8'h00, 8'h55};
        req_wdata = {32'h0, 32'hAA};
        tick();
        req_valid = 2'b00;
        check("rst_mid_we", 64'(mem_we), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        check_quiet("rst_mid");
        rst = 1'b0;
        tick();
        check("rst_mid_no_rsp", 64'(rsp_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        req_valid = 2'b11;
        settle();
        check("rst_mid_tie", 64'(req_ready), 64'h1);
        req_valid = 2'b00;
        req_write = 2'b00;
        settle();

        // --- spurious ack in IDLE and DONE ---
        mem_ack = 1'b1;
        tick();
        check("spur_idle_busy", 64'(busy), 64'd0);
        check("spur_idle_rsp", 64'(rsp_valid), 64'd0);
        check("spur_idle_en", 64'(mem_en), 64'd0);
        mem_ack   = 1'b0;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
        tick();
        check("spur_rsp_valid", 64'(rsp_valid), 64'h1);
        check("spur_rsp_data", 64'(rsp_data), 64'h0BADF00D);
        tick();
        check("spur_done_rsp", 64'(rsp_valid), 64'd0);
        check("spur_done_busy", 64'(busy), 64'd0);
        tick();
        check("spur_idle2_rsp", 64'(rsp_valid), 64'd0);
        check("spur_idle2_busy", 64'(busy), 64'd0);
        mem_ack = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
